// File: rtl/pio_key_debounce_pkg.sv
// Shared constants and helpers for the PIO key debouncer.
// The default debounce window is derived from the system clock rate so that
// a change must persist for 10 ms before it reaches the PIO.
package pio_key_debounce_pkg;

    localparam int unsigned CLK_HZ                  = 32'd50_000_000;
    localparam int unsigned DEBOUNCE_MS             = 32'd10;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 32'd1000) * DEBOUNCE_MS;

    // Ceiling log2: number of bits needed to count 0 .. value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (((value - 32'd1) >> i) != 32'd0) begin
                result = 32'(i + 1);
            end
        end
        return result;
    endfunction

endpackage : pio_key_debounce_pkg

// File: rtl/pio_key_debounce_debounce_channel.sv
// One debounced input channel: 2-flop synchroniser, persistence counter,
// accepted-level flop and one-cycle rise/fall pulse flops.
// The synchroniser carries the raw pin level and resets to the pin's idle
// level (INVERT), so the normalised level seen by the counter is 0 out of
// reset and no spurious edge is reported after reset release.
module debounce_channel
    import pio_key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          INVERT          = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_in,
    output logic data_out,
    output logic rise,
    output logic fall
);

    localparam int unsigned   CW        = clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic          PIN_IDLE  = INVERT;

    logic          sync1_q;
    logic          sync2_q;
    logic          level_s;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stable_q;
    logic          stable_d;
    logic          rise_q;
    logic          rise_d;
    logic          fall_q;
    logic          fall_d;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= PIN_IDLE;
            sync2_q <= PIN_IDLE;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    // Normalised level: 1 = asserted/pressed.
    assign level_s = sync2_q ^ INVERT;

    // Persistence counter: a differing level must hold for DEBOUNCE_CYCLES
    // consecutive samples; any return to the accepted level restarts it.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (level_s == stable_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            stable_d = level_s;
            cnt_d    = {CW{1'b0}};
            rise_d   = level_s;
            fall_d   = ~level_s;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter, accepted level and edge-pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= {CW{1'b0}};
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign data_out = stable_q;
    assign rise     = rise_q;
    assign fall     = fall_q;

endmodule : debounce_channel

// File: rtl/pio_key_debounce.sv
// Input conditioner in front of the Nios PIO in_port: synchronises,
// debounces and polarity-normalises WIDTH raw key/switch lines and provides
// per-channel one-cycle rise/fall pulses. Every output is a flop output.
module pio_key_debounce
    import pio_key_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          INVERT          = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (INVERT)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw_in   (raw_in[i]),
            .data_out (data_out[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

endmodule : pio_key_debounce

// File: tb/tb_pio_key_debounce.sv
// Directed bench for pio_key_debounce with DEBOUNCE_CYCLES=4: an active-low
// instance (INVERT=1) and a pass-through instance (INVERT=0).
module tb_pio_key_debounce;

    logic       clk;
    logic       reset_n;
    logic [3:0] raw0;
    logic [3:0] dout0, rise0, fall0;
    logic [3:0] raw1;
    logic [3:0] dout1, rise1, fall1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    pio_key_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .INVERT(1'b1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .raw_in(raw0),
        .data_out(dout0), .rise(rise0), .fall(fall0)
    );

    pio_key_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .INVERT(1'b0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .raw_in(raw1),
        .data_out(dout1), .rise(rise1), .fall(fall1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check0(input string tag, input logic [3:0] d, input logic [3:0] r, input logic [3:0] f);
        check_eq({tag, "_data"}, 32'(dout0), 32'(d));
        check_eq({tag, "_rise"}, 32'(rise0), 32'(r));
        check_eq({tag, "_fall"}, 32'(fall0), 32'(f));
    endtask

    initial begin
        raw0    = 4'hF;
        raw1    = 4'h0;
        reset_n = 1'b1;

        // 1. asynchronous reset between edges, then 20 idle cycles
        #2 reset_n = 1'b0;
        #1;
        check0("rst_async", 4'h0, 4'h0, 4'h0);
        check_eq("rst_async_inv0", 32'(dout1), 32'h0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check0("idle", 4'h0, 4'h0, 4'h0);
            check_eq("idle_inv0_data", 32'(dout1), 32'h0);
            check_eq("idle_inv0_rise", 32'(rise1), 32'h0);
        end

        // 2. clean press of bit0, then release
        raw0 = 4'hE;
        tick(5);
        check0("press_e4", 4'h0, 4'h0, 4'h0);
        tick(1);
        check0("press_e5", 4'h1, 4'h1, 4'h0);
        tick(1);
        check0("press_e6", 4'h1, 4'h0, 4'h0);
        raw0 = 4'hF;
        tick(5);
        check0("release_e4", 4'h1, 4'h0, 4'h0);
        tick(1);
        check0("release_e5", 4'h0, 4'h0, 4'h1);
        tick(1);
        check0("release_e6", 4'h0, 4'h0, 4'h0);

        // 3. bit1 bounces 3 low / 1 high five times, then holds low
        for (int rep = 0; rep < 5; rep++) begin
            raw0 = 4'hD;
            for (int k = 0; k < 3; k++) begin
                tick(1);
                check0("bounce_lo", 4'h0, 4'h0, 4'h0);
            end
            raw0 = 4'hF;
            tick(1);
            check0("bounce_hi", 4'h0, 4'h0, 4'h0);
        end
        raw0 = 4'hD;
        tick(5);
        check0("settle_e4", 4'h0, 4'h0, 4'h0);
        tick(1);
        check0("settle_e5", 4'h2, 4'h2, 4'h0);

        // move to data_out=8: release bit1 and press bit3 together
        raw0 = 4'h7;
        tick(5);
        check0("to8_e4", 4'h2, 4'h0, 4'h0);
        tick(1);
        check0("to8_e5", 4'h8, 4'h8, 4'h2);
        tick(1);
        check0("to8_e6", 4'h8, 4'h0, 4'h0);

        // 4. simultaneous press bit2 / release bit3
        raw0 = 4'hB;
        tick(5);
        check0("simul_e4", 4'h8, 4'h0, 4'h0);
        tick(1);
        check0("simul_e5", 4'h4, 4'h4, 4'h8);
        tick(1);
        check0("simul_e6", 4'h4, 4'h0, 4'h0);

        // 5. reset in the middle of a bit0 count
        raw0 = 4'hA;
        tick(3);
        check0("midcnt", 4'h4, 4'h0, 4'h0);
        #1 reset_n = 1'b0;
        #1;
        check0("midcnt_rst", 4'h0, 4'h0, 4'h0);
        #1 reset_n = 1'b1;
        tick(5);
        check0("postrst_e4", 4'h0, 4'h0, 4'h0);
        tick(1);
        check0("postrst_e5", 4'h5, 4'h5, 4'h0);

        // 6. pass-through polarity instance
        check_eq("inv0_pre_data", 32'(dout1), 32'h0);
        check_eq("inv0_pre_rise", 32'(rise1), 32'h0);
        raw1 = 4'h1;
        tick(5);
        check_eq("inv0_e4_data", 32'(dout1), 32'h0);
        tick(1);
        check_eq("inv0_e5_data", 32'(dout1), 32'h1);
        check_eq("inv0_e5_rise", 32'(rise1), 32'h1);
        check_eq("inv0_e5_fall", 32'(fall1), 32'h0);
        tick(1);
        check_eq("inv0_e6_rise", 32'(rise1), 32'h0);
        check_eq("inv0_e6_data", 32'(dout1), 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_pio_key_debounce
